// File: rtl/video_pattern_pkg.sv
// Shared modes, FSM encoding and width helper for the AXI4-Stream video pattern generator.
package video_pattern_pkg;

  localparam logic [1:0] MODE_SOLID   = 2'd0;
  localparam logic [1:0] MODE_CHECKER = 2'd1;
  localparam logic [1:0] MODE_GRAD    = 2'd2;
  localparam logic [1:0] MODE_BARS    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pattern_pixel_calc.sv
// Combinational pixel function: (x, y, mode, colours) -> pixel.
// Shared by the generator and the frame checker.
module pattern_pixel_calc
  import video_pattern_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DATA_WIDTH = 24,
  parameter int TILE_LOG2  = 3,
  parameter int XW         = 5,
  parameter int YW         = 4
) (
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] fg_color,
  input  logic [DATA_WIDTH-1:0] bg_color,
  output logic [DATA_WIDTH-1:0] pixel
);

  localparam int CW   = DATA_WIDTH / 3;
  localparam int EW   = (XW > CW) ? XW : CW;
  localparam int BARW = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;

  logic [XW-1:0] xs;
  logic [YW-1:0] ys;
  logic [EW-1:0] xe;
  logic [XW+2:0] bq;
  logic [2:0]    b;

  always_comb begin
    xs = x >> TILE_LOG2;
    ys = y >> TILE_LOG2;
    xe = EW'(x);
    // bar index saturates so leftover pixels of a non-multiple-of-8 width stay white
    bq = (XW+3)'(x) / (XW+3)'(BARW);
    b  = (bq > (XW+3)'(7)) ? 3'd7 : bq[2:0];
    pixel = fg_color;
    unique case (1'b1)
      mode == MODE_SOLID:   pixel = fg_color;
      mode == MODE_CHECKER: pixel = (xs[0] ^ ys[0]) ? bg_color : fg_color;
      mode == MODE_GRAD:    pixel = {3{xe[CW-1:0]}};
      mode == MODE_BARS:    pixel = {{CW{b[2]}}, {CW{b[1]}}, {CW{b[0]}}};
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video pattern source with SOF/EOL framing and back-pressure.
// Optional per-frame checksum ports when PATTERN_GEN_CHECKSUM_EN is defined.
module axis_video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 16,
  parameter int DATA_WIDTH = 24,
  parameter int TILE_LOG2  = 3,
  parameter int FRAME_GAP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] fg_color,
  input  logic [DATA_WIDTH-1:0] bg_color,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
`ifdef PATTERN_GEN_CHECKSUM_EN
  output logic [31:0]           frame_checksum,
  output logic                  checksum_valid,
`endif
  output logic                  busy
);

  localparam int XW       = clog2(WIDTH);
  localparam int YW       = clog2(HEIGHT);
  localparam int GW       = clog2(FRAME_GAP + 1);
  localparam int GAP_LAST = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;
  localparam bit NO_GAP   = (FRAME_GAP == 0);

  state_t                state;
  logic [XW-1:0]         x, nx, px_x;
  logic [YW-1:0]         y, ny, px_y;
  logic [GW-1:0]         gap_cnt;
  logic [1:0]            mode_q, px_mode;
  logic [DATA_WIDTH-1:0] fg_q, bg_q, px_fg, px_bg, pixel;
  logic                  xfer, last_px, gap_last, start;

  always_comb begin
    xfer     = m_axis_tvalid & m_axis_tready;
    last_px  = (x == XW'(WIDTH-1)) && (y == YW'(HEIGHT-1));
    gap_last = (gap_cnt == GW'(GAP_LAST));
    start    = enable & ((state == ST_IDLE)
             | ((state == ST_GAP) & gap_last)
             | (NO_GAP & (state == ST_ACTIVE) & xfer & last_px));
    nx = (x == XW'(WIDTH-1)) ? '0 : x + XW'(1);
    ny = y;
    if (x == XW'(WIDTH-1))
      ny = (y == YW'(HEIGHT-1)) ? '0 : y + YW'(1);
    // a frame start computes pixel (0,0) from the live config being latched
    px_x    = start ? '0 : nx;
    px_y    = start ? '0 : ny;
    px_mode = start ? mode : mode_q;
    px_fg   = start ? fg_color : fg_q;
    px_bg   = start ? bg_color : bg_q;
  end

  pattern_pixel_calc #(
    .WIDTH      (WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TILE_LOG2  (TILE_LOG2),
    .XW         (XW),
    .YW         (YW)
  ) u_calc (
    .x        (px_x),
    .y        (px_y),
    .mode     (px_mode),
    .fg_color (px_fg),
    .bg_color (px_bg),
    .pixel    (pixel)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      x             <= '0;
      y             <= '0;
      gap_cnt       <= '0;
      mode_q        <= '0;
      fg_q          <= '0;
      bg_q          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: ;
        ST_ACTIVE: begin
          if (xfer) begin
            x <= nx;
            y <= ny;
            if (last_px) begin
              frame_done    <= 1'b1;
              frame_count   <= frame_count + 16'd1;
              m_axis_tvalid <= 1'b0;
              m_axis_tuser  <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tdata  <= '0;
              state         <= NO_GAP ? ST_IDLE : ST_GAP;
            end else begin
              m_axis_tdata <= pixel;
              m_axis_tuser <= 1'b0;
              m_axis_tlast <= (nx == XW'(WIDTH-1));
            end
          end
        end
        ST_GAP: begin
          if (gap_last) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
      // later assignments win: a start overrides the end-of-frame/gap defaults
      if (start) begin
        state         <= ST_ACTIVE;
        mode_q        <= mode;
        fg_q          <= fg_color;
        bg_q          <= bg_color;
        x             <= '0;
        y             <= '0;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= pixel;
        m_axis_tuser  <= 1'b1;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

`ifdef PATTERN_GEN_CHECKSUM_EN
  logic [31:0] acc, acc_n;

  always_comb
    acc_n = (m_axis_tuser ? 32'd0 : acc) + 32'(m_axis_tdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc            <= '0;
      frame_checksum <= '0;
      checksum_valid <= 1'b0;
    end else begin
      checksum_valid <= 1'b0;
      if (xfer) begin
        acc <= acc_n;
        if (last_px) begin
          frame_checksum <= acc_n;
          checksum_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Self-checking bench for axis_video_pattern_gen: scoreboard plus table of pixel vectors.
// Checksum checks compile in when PATTERN_GEN_CHECKSUM_EN is defined.
module tb_axis_video_pattern_gen;

  localparam int W    = 32;
  localparam int H    = 16;
  localparam int DW   = 24;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] fg = '0;
  logic [DW-1:0] bg = '0;
  logic          tready = 1'b1;
  logic [DW-1:0] tdata;
  logic          tvalid, tuser, tlast, frame_done, busy;
  logic [15:0]   frame_count;
`ifdef PATTERN_GEN_CHECKSUM_EN
  logic [31:0]   frame_checksum;
  logic          checksum_valid;
  logic [31:0]   cs_seen;
  logic          csv_seen;
`endif

  axis_video_pattern_gen #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .TILE_LOG2(3), .FRAME_GAP(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .mode           (mode),
    .fg_color       (fg),
    .bg_color       (bg),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tuser   (tuser),
    .m_axis_tlast   (tlast),
    .frame_done     (frame_done),
    .frame_count    (frame_count),
`ifdef PATTERN_GEN_CHECKSUM_EN
    .frame_checksum (frame_checksum),
    .checksum_valid (checksum_valid),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] fg;
    logic [DW-1:0] bg;
    int            idx;
    logic [DW-1:0] exp;
    bit            rnd;
  } vec_t;

  beat_t         exp_q[$];
  vec_t          vecs[16];
  logic [DW-1:0] got[NPIX];
  int            checks = 0;
  int            errors = 0;
  int            pix_idx = 0;
  int            xfers = 0;
  int            exp_count = 0;
  int            last_latency = 0;
  bit            in_frame = 0;
  bit            prev_stall = 0;
  bit            rand_ready = 0;
  beat_t         prev_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [1:0] m, input logic [DW-1:0] f,
                                          input logic [DW-1:0] b, input int x, input int y);
    int bi;
    logic [7:0] c;
    case (m)
      2'd0: return f;
      2'd1: return ((((x / 8) + (y / 8)) % 2) == 0) ? f : b;
      2'd2: begin
        c = 8'(x % 256);
        return {c, c, c};
      end
      default: begin
        bi = x / (W / 8);
        if (bi > 7) bi = 7;
        return {((bi & 4) != 0) ? 8'hFF : 8'h00,
                ((bi & 2) != 0) ? 8'hFF : 8'h00,
                ((bi & 1) != 0) ? 8'hFF : 8'h00};
      end
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] m, input logic [DW-1:0] f, input logic [DW-1:0] b);
    beat_t e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.data = model(m, f, b, x, y);
        e.user = (x == 0 && y == 0);
        e.last = (x == W - 1);
        exp_q.push_back(e);
      end
  endtask

  // monitor: scoreboard pop, stall stability, tvalid continuity
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 0;
      in_frame   = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tvalid), 32'd1);
        check("stall_data", 32'(tdata), 32'(prev_b.data));
        check("stall_last", 32'(tlast), 32'(prev_b.last));
        check("stall_user", 32'(tuser), 32'(prev_b.user));
      end else if (in_frame) begin
        check("valid_in_frame", 32'(tvalid), 32'd1);
      end
      if (tvalid && tready) begin
        if (tuser) pix_idx = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(tdata), 32'(e.data));
          check("beat_user", 32'(tuser), 32'(e.user));
          check("beat_last", 32'(tlast), 32'(e.last));
        end
        if (pix_idx < NPIX) got[pix_idx] = tdata;
        pix_idx++;
        xfers++;
        in_frame = (pix_idx < NPIX);
      end
      prev_stall  = tvalid && !tready;
      prev_b.data = tdata;
      prev_b.user = tuser;
      prev_b.last = tlast;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 20000);
    last_latency = n;
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got 0 expected 1");
    end
`ifdef PATTERN_GEN_CHECKSUM_EN
    cs_seen  = frame_checksum;
    csv_seen = checksum_valid;
`endif
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic wait_xfers(input int target);
    int n;
    n = 0;
    while (xfers < target && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("xfer_reached", 32'(xfers >= target), 32'd1);
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [DW-1:0] f,
                           input logic [DW-1:0] b, input bit rnd);
    rand_ready = rnd;
    push_frame(m, f, b);
    @(posedge clk);
    #1 mode = m; fg = f; bg = b; enable = 1'b1;
    @(posedge clk);
    // scrambled inputs after SOF must not affect the latched frame
    #1 enable = 1'b0; mode = m + 2'd1; fg = ~f; bg = ~b;
    wait_done();
    if (!rnd) check("frame_done_latency", 32'(last_latency), 32'd513);
    wait_idle();
    rand_ready = 0;
    exp_count++;
    check("frame_count", 32'(frame_count), 32'(exp_count));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    vecs[0]  = '{2'd1, 24'hFFFFFF, 24'h000000, 0,   24'hFFFFFF, 1'b0};
    vecs[1]  = '{2'd1, 24'hFFFFFF, 24'h000000, 8,   24'h000000, 1'b0};
    vecs[2]  = '{2'd1, 24'hFFFFFF, 24'h000000, 264, 24'hFFFFFF, 1'b0};
    vecs[3]  = '{2'd1, 24'hFFFFFF, 24'h000000, 256, 24'h000000, 1'b0};
    vecs[4]  = '{2'd3, 24'h000000, 24'h000000, 0,   24'h000000, 1'b0};
    vecs[5]  = '{2'd3, 24'h000000, 24'h000000, 3,   24'h000000, 1'b0};
    vecs[6]  = '{2'd3, 24'h000000, 24'h000000, 4,   24'h0000FF, 1'b0};
    vecs[7]  = '{2'd3, 24'h000000, 24'h000000, 8,   24'h00FF00, 1'b0};
    vecs[8]  = '{2'd3, 24'h000000, 24'h000000, 31,  24'hFFFFFF, 1'b0};
    vecs[9]  = '{2'd2, 24'h000000, 24'h000000, 5,   24'h050505, 1'b0};
    vecs[10] = '{2'd2, 24'h000000, 24'h000000, 31,  24'h1F1F1F, 1'b0};
    vecs[11] = '{2'd2, 24'h000000, 24'h000000, 37,  24'h050505, 1'b0};
    vecs[12] = '{2'd0, 24'h123456, 24'h000000, 0,   24'h123456, 1'b0};
    vecs[13] = '{2'd0, 24'h123456, 24'h000000, 511, 24'h123456, 1'b0};
    vecs[14] = '{2'd1, 24'hA5A5A5, 24'h5A5A5A, 0,   24'hA5A5A5, 1'b1};
    vecs[15] = '{2'd1, 24'hA5A5A5, 24'h5A5A5A, 8,   24'h5A5A5A, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tuser", 32'(tuser), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // enable dropped mid-frame: frame completes, gap, then idle
    push_frame(2'd1, 24'hFFFFFF, 24'h000000);
    @(posedge clk);
    #1 mode = 2'd1; fg = 24'hFFFFFF; bg = 24'h000000; enable = 1'b1;
    wait_xfers(100);
    #1 enable = 1'b0;
    wait_done();
    g = 0;
    while (busy && g < 100) begin
      check("gap_tvalid_low", 32'(tvalid), 32'd0);
      g++;
      @(negedge clk);
    end
    check("gap_cycles", 32'(g), 32'd4);
    check("enable_low_count", 32'(frame_count), 32'd1);
    check("enable_low_busy", 32'(busy), 32'd0);
    exp_count = 1;

    // table of pixel vectors, one frame per distinct config
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || vecs[i].mode != vecs[i-1].mode || vecs[i].fg != vecs[i-1].fg
          || vecs[i].bg != vecs[i-1].bg)
        run_frame(vecs[i].mode, vecs[i].fg, vecs[i].bg, vecs[i].rnd);
      check($sformatf("vec%0d_pixel%0d", i, vecs[i].idx), 32'(got[vecs[i].idx]), 32'(vecs[i].exp));
    end

    // enable held: back-to-back frames separated by exactly the gap
    push_frame(2'd2, 24'h0, 24'h0);
    push_frame(2'd2, 24'h0, 24'h0);
    @(posedge clk);
    #1 mode = 2'd2; enable = 1'b1;
    wait_done();
    g = 0;
    while (!tvalid && g < 100) begin
      g++;
      @(negedge clk);
    end
    check("b2b_gap_len", 32'(g), 32'd4);
    @(posedge clk);
    #1 enable = 1'b0;
    wait_done();
    wait_idle();
    exp_count += 2;
    check("b2b_frame_count", 32'(frame_count), 32'(exp_count));

    // asynchronous reset mid-frame
    push_frame(2'd1, 24'hFFFFFF, 24'h000000);
    @(posedge clk);
    #1 mode = 2'd1; fg = 24'hFFFFFF; bg = 24'h000000; enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    wait_xfers(xfers + 200);
    #2 rst = 1'b1;
    #1;
    check("arst_tvalid", 32'(tvalid), 32'd0);
    check("arst_tdata", 32'(tdata), 32'd0);
    check("arst_tuser", 32'(tuser), 32'd0);
    check("arst_tlast", 32'(tlast), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    exp_count = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    run_frame(2'd1, 24'hFFFFFF, 24'h000000, 1'b0);

`ifdef PATTERN_GEN_CHECKSUM_EN
    run_frame(2'd0, 24'h000001, 24'h000000, 1'b0);
    check("checksum_value", cs_seen, 32'h200);
    check("checksum_valid", 32'(csv_seen), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
